// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - two-master request ports and shared RAM bus for ram_arbiter
interface ram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] address_bus;
  logic [DATA_W-1:0] wdata_bus;
  logic [1:0]        control_bus;
  logic [DATA_W-1:0] rdata_bus;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  rdata_bus,
    output gnt0, ack0, rdata0,
    output gnt1, ack1, rdata1,
    output address_bus, wdata_bus, control_bus
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output rdata_bus,
    input  gnt0, ack0, rdata0,
    input  gnt1, ack1, rdata1,
    input  address_bus, wdata_bus, control_bus
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-master arbiter and sequencer for the shared RAM bus
module ram_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 1
) (
  input logic            clk,
  input logic            reset,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_INIT = 4'(RAM_LATENCY - 1);

  state_t            state, state_d;
  logic              last_grant, last_grant_d;
  logic              owner, owner_d;
  logic              we_q, we_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= 2'b00;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      owner      <= owner_d;
      we_q       <= we_d;
      cnt        <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    owner_d      = owner;
    we_d         = we_q;
    cnt_d        = cnt;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ctrl_d       = ctrl_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // On a tie the master that did not win last time goes first.
    pick         = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          ctrl_d  = we_d ? 2'b01 : 2'b10;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          cnt_d   = LAT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (!we_q) begin
            if (owner) rdata1_d = bus.rdata_bus;
            else       rdata0_d = bus.rdata_bus;
          end
          ctrl_d  = 2'b00;
          ack0_d  = ~owner;
          ack1_d  = owner;
          state_d = DONE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE: begin
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        last_grant_d = owner;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.address_bus = addr_q;
  assign bus.wdata_bus   = wdata_q;
  assign bus.control_bus = ctrl_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter at RAM_LATENCY 1 and 3
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus1 ();
  ram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus3 ();

  ram_arbiter #(.ADDR_W(24), .DATA_W(32), .RAM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  ram_arbiter #(.ADDR_W(24), .DATA_W(32), .RAM_LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.req0 = 0; bus1.we0 = 0; bus1.addr0 = '0; bus1.wdata0 = '0;
    bus1.req1 = 0; bus1.we1 = 0; bus1.addr1 = '0; bus1.wdata1 = '0;
    bus1.rdata_bus = '0;
    bus3.req0 = 0; bus3.we0 = 0; bus3.addr0 = '0; bus3.wdata0 = '0;
    bus3.req1 = 0; bus3.we1 = 0; bus3.addr1 = '0; bus3.wdata1 = '0;
    bus3.rdata_bus = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    total++; if (bus1.gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%0h exp=0", bus1.gnt0); end
    total++; if (bus1.gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%0h exp=0", bus1.gnt1); end
    total++; if (bus1.ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack0 got=%0h exp=0", bus1.ack0); end
    total++; if (bus1.ack1 !== 1'b0) begin bad++; $display("FAIL reset_ack1 got=%0h exp=0", bus1.ack1); end
    total++; if (bus1.rdata0 !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%0h exp=0", bus1.rdata0); end
    total++; if (bus1.rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%0h exp=0", bus1.rdata1); end
    total++; if (bus1.address_bus !== 24'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus1.address_bus); end
    total++; if (bus1.wdata_bus !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", bus1.wdata_bus); end
    total++; if (bus1.control_bus !== 2'b00) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", bus1.control_bus); end
    total++; if (bus3.control_bus !== 2'b00) begin bad++; $display("FAIL reset_ctrl3 got=%0h exp=0", bus3.control_bus); end
    total++; if (bus3.gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0_3 got=%0h exp=0", bus3.gnt0); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 24'h000010; bus1.rdata_bus = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if ((bus1.gnt1 | bus1.ack1) !== 1'b0) begin bad++; $display("FAIL read_m1_quiet k=%0d got=%0h exp=0", k, bus1.gnt1 | bus1.ack1); end
      if (k == 1) begin
        total++; if (bus1.control_bus !== 2'b10) begin bad++; $display("FAIL read_ctrl got=%0h exp=2", bus1.control_bus); end
        total++; if (bus1.address_bus !== 24'h000010) begin bad++; $display("FAIL read_addr got=%0h exp=10", bus1.address_bus); end
        total++; if (bus1.gnt0 !== 1'b1) begin bad++; $display("FAIL read_gnt0_access got=%0h exp=1", bus1.gnt0); end
        total++; if (bus1.ack0 !== 1'b0) begin bad++; $display("FAIL read_ack0_early got=%0h exp=0", bus1.ack0); end
      end else if (k == 2) begin
        total++; if (bus1.ack0 !== 1'b1) begin bad++; $display("FAIL read_ack0 got=%0h exp=1", bus1.ack0); end
        total++; if (bus1.rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata0 got=%0h exp=deadbeef", bus1.rdata0); end
        total++; if (bus1.control_bus !== 2'b00) begin bad++; $display("FAIL read_ctrl_done got=%0h exp=0", bus1.control_bus); end
        total++; if (bus1.gnt0 !== 1'b1) begin bad++; $display("FAIL read_gnt0_done got=%0h exp=1", bus1.gnt0); end
        bus1.req0 = 0;
      end else begin
        total++; if (bus1.gnt0 !== 1'b0) begin bad++; $display("FAIL read_gnt0_idle got=%0h exp=0", bus1.gnt0); end
        total++; if (bus1.ack0 !== 1'b0) begin bad++; $display("FAIL read_ack0_idle got=%0h exp=0", bus1.ack0); end
        total++; if (bus1.rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata0_hold got=%0h exp=deadbeef", bus1.rdata0); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    bus3.req1 = 1; bus3.we1 = 1; bus3.addr1 = 24'h00FFFF; bus3.wdata1 = 32'h12345678;
    bus3.rdata_bus = 32'hCAFEF00D;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (bus3.control_bus !== ((k <= 3) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL write_ctrl k=%0d got=%0h", k, bus3.control_bus); end
      total++; if (bus3.ack1 !== (k == 4)) begin bad++; $display("FAIL write_ack1 k=%0d got=%0h exp=%0h", k, bus3.ack1, k == 4); end
      total++; if (bus3.gnt1 !== (k <= 4)) begin bad++; $display("FAIL write_gnt1 k=%0d got=%0h exp=%0h", k, bus3.gnt1, k <= 4); end
      total++; if (bus3.rdata1 !== 32'h0) begin bad++; $display("FAIL write_rdata1 k=%0d got=%0h exp=0", k, bus3.rdata1); end
      total++; if ((bus3.gnt0 | bus3.ack0) !== 1'b0) begin bad++; $display("FAIL write_m0_quiet k=%0d got=1 exp=0", k); end
      if (k <= 3) begin
        total++; if (bus3.address_bus !== 24'h00FFFF) begin bad++; $display("FAIL write_addr k=%0d got=%0h exp=ffff", k, bus3.address_bus); end
        total++; if (bus3.wdata_bus !== 32'h12345678) begin bad++; $display("FAIL write_wdata k=%0d got=%0h exp=12345678", k, bus3.wdata_bus); end
      end
      if (k == 4) bus3.req1 = 0;
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus1.req0 = 1; bus1.addr0 = 24'h000100;
    bus1.req1 = 1; bus1.addr1 = 24'h000200;
    for (int k = 1; k <= 9; k++) begin
      step();
      total++; if (bus1.gnt0 !== (k inside {1, 2, 7, 8})) begin bad++; $display("FAIL rr_gnt0 k=%0d got=%0h", k, bus1.gnt0); end
      total++; if (bus1.gnt1 !== (k inside {4, 5})) begin bad++; $display("FAIL rr_gnt1 k=%0d got=%0h", k, bus1.gnt1); end
      total++; if (bus1.ack0 !== (k == 2 || k == 8)) begin bad++; $display("FAIL rr_ack0 k=%0d got=%0h", k, bus1.ack0); end
      total++; if (bus1.ack1 !== (k == 5)) begin bad++; $display("FAIL rr_ack1 k=%0d got=%0h", k, bus1.ack1); end
      if (k == 4) begin
        total++; if (bus1.address_bus !== 24'h000200) begin bad++; $display("FAIL rr_addr1 got=%0h exp=200", bus1.address_bus); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_no_starvation();
    int first_ack1;
    do_reset();
    bus1.req0 = 1; bus1.addr0 = 24'h000300;
    step();
    bus1.req1 = 1; bus1.addr1 = 24'h000400;
    first_ack1 = -1;
    for (int k = 2; k <= 12; k++) begin
      step();
      if (k == 2) begin
        total++; if (bus1.ack0 !== 1'b1) begin bad++; $display("FAIL starve_ack0 got=%0h exp=1", bus1.ack0); end
      end
      if (bus1.ack1 === 1'b1 && first_ack1 < 0) begin
        first_ack1 = k;
        bus1.req1 = 0;
      end
    end
    total++; if (first_ack1 != 5) begin bad++; $display("FAIL starve_ack1_cycle got=%0d exp=5", first_ack1); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int first_ack0;
    do_reset();
    bus3.req0 = 1; bus3.we0 = 0; bus3.addr0 = 24'h000020; bus3.rdata_bus = 32'h00000055;
    step();
    step();
    total++; if (bus3.control_bus !== 2'b10) begin bad++; $display("FAIL rmid_ctrl_before got=%0h exp=2", bus3.control_bus); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus3.control_bus !== 2'b00) begin bad++; $display("FAIL rmid_ctrl got=%0h exp=0", bus3.control_bus); end
    total++; if (bus3.gnt0 !== 1'b0) begin bad++; $display("FAIL rmid_gnt0 got=%0h exp=0", bus3.gnt0); end
    total++; if (bus3.address_bus !== 24'h0) begin bad++; $display("FAIL rmid_addr got=%0h exp=0", bus3.address_bus); end
    step();
    total++; if (bus3.ack0 !== 1'b0) begin bad++; $display("FAIL rmid_ack0_in_reset got=%0h exp=0", bus3.ack0); end
    reset = 1'b0;
    first_ack0 = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus3.ack0 === 1'b1 && first_ack0 < 0) begin
        first_ack0 = k;
        total++; if (bus3.rdata0 !== 32'h00000055) begin bad++; $display("FAIL rmid_rdata0 got=%0h exp=55", bus3.rdata0); end
        bus3.req0 = 0;
      end
    end
    total++; if (first_ack0 != 4) begin bad++; $display("FAIL rmid_ack_cycle got=%0d exp=4", first_ack0); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 24'h000001; bus1.rdata_bus = 32'hA;
    for (int k = 1; k <= 5; k++) begin
      step();
      case (k)
        1: begin
          total++; if (bus1.address_bus !== 24'h000001) begin bad++; $display("FAIL b2b_addr1 got=%0h exp=1", bus1.address_bus); end
        end
        2: begin
          total++; if (bus1.ack0 !== 1'b1) begin bad++; $display("FAIL b2b_ack_a got=%0h exp=1", bus1.ack0); end
          total++; if (bus1.rdata0 !== 32'hA) begin bad++; $display("FAIL b2b_rdata_a got=%0h exp=a", bus1.rdata0); end
          bus1.addr0 = 24'h000002; bus1.rdata_bus = 32'hB;
        end
        3: begin
          total++; if (bus1.ack0 !== 1'b0) begin bad++; $display("FAIL b2b_ack_idle got=%0h exp=0", bus1.ack0); end
          total++; if (bus1.rdata0 !== 32'hA) begin bad++; $display("FAIL b2b_hold_idle got=%0h exp=a", bus1.rdata0); end
        end
        4: begin
          total++; if (bus1.address_bus !== 24'h000002) begin bad++; $display("FAIL b2b_addr2 got=%0h exp=2", bus1.address_bus); end
          total++; if (bus1.control_bus !== 2'b10) begin bad++; $display("FAIL b2b_ctrl2 got=%0h exp=2", bus1.control_bus); end
          total++; if (bus1.rdata0 !== 32'hA) begin bad++; $display("FAIL b2b_hold_access got=%0h exp=a", bus1.rdata0); end
        end
        default: begin
          total++; if (bus1.ack0 !== 1'b1) begin bad++; $display("FAIL b2b_ack_b got=%0h exp=1", bus1.ack0); end
          total++; if (bus1.rdata0 !== 32'hB) begin bad++; $display("FAIL b2b_rdata_b got=%0h exp=b", bus1.rdata0); end
          bus1.req0 = 0;
        end
      endcase
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_no_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter and sequencer for the single shared RAM bus (24-bit address, 32-bit read/write data, 2-bit control {read, write}). Port 0 carries the processor's memory requests; port 1 carries the secondary master (program loader / DMA). The block latches one request at a time, drives the RAM bus for a fixed latency, captures read data, and returns a one-cycle acknowledge. Ties are resolved round-robin.

## Interface
- ADDR_W, 24, address width
- DATA_W, 32, data width
- RAM_LATENCY, 1, cycles the control strobe is held before read data is valid (legal range 1..15)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0 / req1  in  1  request from master 0 / 1; held high with fields stable until its ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  request address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  master owns the bus (registered)
- ack0 / ack1  out  1  one-cycle completion pulse (registered)
- rdata0 / rdata1  out  DATA_W  captured read data; valid in ack cycle, held until the next read completion for that master
- address_bus  out  ADDR_W  RAM address
- wdata_bus  out  DATA_W  RAM write data
- control_bus  out  2  {ram_read, ram_write}; 2'b00 when idle, never 2'b11
- rdata_bus  in  DATA_W  RAM read data

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: no request -> stay. Exactly one reqN -> grant N. Both -> grant the master not granted last (last_grant resets to 1, so master 0 wins the first tie). On grant: latch addr, we, wdata of winner; gntN <= 1; latency counter <= RAM_LATENCY-1; go ACCESS.
- ACCESS: address_bus/wdata_bus from latched fields; control_bus = we ? 2'b01 : 2'b10. Counter decrements each cycle; when 0: if read, capture rdata_bus into rdataN; go DONE.
- DONE: control_bus = 2'b00; ackN = 1; gntN stays 1; last_grant <= N; go IDLE (gntN <= 0).
- Requests (including the acked master's still-high req) are not sampled in ACCESS or DONE. Master must drop req on the clock edge ending its ack cycle, or a new transaction is issued.
- Write completion does not change rdataN.
- Losing master's request is held pending, never dropped; it wins the next IDLE (round-robin guarantees no starvation).
- address_bus/wdata_bus hold last latched values when idle; only control_bus qualifies them.

## Timing
- Reset values: gnt0/1=0, ack0/1=0, rdata0/1=0, address_bus=0, wdata_bus=0, control_bus=2'b00, last_grant=1, state IDLE.
- Cycle T: req sampled high in IDLE. T+1..T+RAM_LATENCY: ACCESS, strobe active. T+RAM_LATENCY+1: DONE, ack high, rdata valid. T+RAM_LATENCY+2: IDLE, earliest next grant sampling.
- Throughput: one transaction per RAM_LATENCY+2 cycles; both masters continuously requesting alternate 0,1,0,1.
- gntN high exactly RAM_LATENCY+1 cycles per transaction; ack exactly 1.
- Reset asserted mid-ACCESS or DONE: all outputs return to reset values asynchronously, transaction abandoned, no ack issued; after release, IDLE re-samples requests.
- All outputs registered; no combinational path from any input to any output.

## Test plan
- Single read, RAM_LATENCY=1: req0, we0=0, addr0=0x000010, RAM returns 0xDEADBEEF -> control_bus=2'b10 for 1 cycle at addr 0x000010, next cycle ack0=1, rdata0=0xDEADBEEF; gnt1/ack1 never high.
- Single write, RAM_LATENCY=3: req1, we1=1, addr1=0x00FFFF, wdata1=0x12345678 -> control_bus=2'b01 for exactly 3 cycles with those values on buses, then ack1 one cycle, rdata1 unchanged.
- Simultaneous requests after reset, both held: master 0 served first, then master 1, then 0; grants never overlap; each transaction exactly RAM_LATENCY+2 cycles apart.
- Master 0 holds req continuously (re-requests after each ack) while master 1 requests once -> master 1 acked within one transaction of its request (no starvation).
- Reset asserted during second ACCESS cycle of a RAM_LATENCY=3 read -> control_bus=2'b00, gnt=0 immediately, no ack; after release with req still high, transaction restarts from IDLE and completes normally.
- Back-to-back reads by master 0 from 0x000001 (data 0xA) then 0x000002 (data 0xB) -> rdata0 shows 0xA in first ack cycle, holds 0xA until second ack cycle shows 0xB.
